// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to abort a frame whose tx_done never arrives.
module uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   busy,
    output logic [2:0]             gnt_id,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t               state_q;
    logic [2:0]           last_q, gnt_q, win_d;
    logic [7:0]           tx_data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 trmt_q, busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0]        cnt_q;
    logic                 err_q;
`endif
    // Winner is the requester at the smallest rotational distance past last_q.
    always_comb begin
        int best;
        int d;
        best   = NUM_REQ;
        win_d  = last_q;
        data_d = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + 2 * NUM_REQ - int'(last_q) - 1) % NUM_REQ;
            if (req[i] && d < best) begin
                best   = d;
                win_d  = 3'(i);
                data_d = req_data[8*i +: 8];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 3'(NUM_REQ - 1);
            gnt_q     <= 3'd0;
            tx_data_q <= 8'h00;
            ack_q     <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    gnt_q     <= win_d;
                    tx_data_q <= data_d;
                    trmt_q    <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    trmt_q  <= 1'b0;
                    state_q <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    if (tx_done) begin
                        ack_q   <= NUM_REQ'(1) << gnt_q;
                        state_q <= ACK;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        ack_q   <= NUM_REQ'(1) << gnt_q;
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= gnt_q;
                    state_q <= IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
            endcase
        end
    end
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_q;
    assign trmt    = trmt_q;
    assign tx_data = tx_data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a rotation model
// and a simple transmitter model with a configurable frame length.
module tb_uart_tx_arb;
    localparam int N  = 4;
    localparam int TO = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic         err, busy, trmt, tx_done;
    logic [2:0]   gnt_id;
    logic [7:0]   tx_data;

    int total = 0;
    int bad = 0;
    int m_last = N - 1;
    int frame_len = 20;
    bit tx_stuck = 0;
    int tx_cnt;

    uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
        .busy(busy), .gnt_id(gnt_id), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Transmitter: clears done on the edge that samples trmt, raises it frame_len edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done <= 1'b1;
            tx_cnt  <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            tx_cnt  <= frame_len;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1 && !tx_stuck) tx_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Rotation rule: first set bit at last+1, last+2, ... modulo N.
    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trmt", trmt, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_gnt", gnt_id, 0);
        rst = 1'b0;
        m_last = N - 1;
        @(negedge clk);
    endtask

    task automatic wait_trmt(output int lat);
        bit seen = 0;
        lat = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            seen = trmt;
        end
        chk("trmt_seen", seen, 1);
    endtask

    // One frame: grant check, optional req edits during WAIT, ack check.
    task automatic serve(input bit drop, input logic [N-1:0] set_m, input logic [N-1:0] clr_m,
                         output int lat);
        int id, n, td, extra;
        logic [7:0] b;
        bit seen;
        id = pick(m_last, req);
        b  = req_data[8*id +: 8];
        wait_trmt(lat);
        chk("tx_data", tx_data, b);
        chk("gnt_id", gnt_id, id);
        chk("busy_issue", busy, 1);
        seen = 0; n = 0; td = -1; extra = 0;
        while (!seen && n < frame_len + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                for (int i = 0; i < N; i++)
                    if (set_m[i] && !req[i]) req_data[8*i +: 8] = 8'($urandom);
                req = (req | set_m) & ~clr_m;
            end
            if (td < 0 && tx_done) td = n;
            if (trmt) extra++;
            seen = |ack;
        end
        chk("ack_seen", seen, 1);
        chk("ack_onehot", ack, 32'd1 << id);
        chk("ack_after_done", n - td, 1);
        chk("err_ok", err, 0);
        chk("extra_trmt", extra, 0);
        m_last = id;
        if (drop) req[id] = 1'b0;
    endtask

    task automatic quiet(input string tag);
        int t = 0;
        repeat (20) begin
            @(negedge clk);
            if (trmt) t++;
        end
        chk(tag, t, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int lat, n, badcyc;
        bit seen;
        do_reset();
        // Single requester, latency.
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        serve(1, 0, 0, lat);
        chk("issue_latency", lat, 1);
        @(negedge clk);
        chk("busy_after", busy, 0);
        // Continuous full request: strict rotation.
        do_reset();
        req_data = 32'h13121110;
        req = 4'b1111;
        repeat (5) serve(0, 0, 0, lat);
        req = '0;
        // Rotation from last=2, late requester served next.
        req = 4'b0100;
        serve(1, 0, 0, lat);
        req = 4'b0101;
        serve(1, 4'b0010, 0, lat);
        serve(1, 0, 0, lat);
        serve(1, 0, 0, lat);
        // Reset mid-frame.
        frame_len = 5000;
        req = 4'b0001;
        wait_trmt(lat);
        chk("mid_gnt", gnt_id, pick(m_last, 4'b0001));
        repeat (4000) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_ack", ack, 0);
        do_reset();
        frame_len = 20;
        req = 4'b0010;
        serve(1, 0, 0, lat);
        // Transmitter never finishes.
        tx_stuck = 1;
        req = 4'b0001;
        wait_trmt(lat);
`ifdef UART_TX_ARB_TIMEOUT_EN
        seen = 0; n = 0;
        while (!seen && n < TO + 50) begin
            @(negedge clk);
            n++;
            seen = |ack;
        end
        chk("to_cycles", n, TO + 1);
        chk("to_ack", ack, 1);
        chk("to_err", err, 1);
`else
        badcyc = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 1'b0 || ack !== '0) badcyc++;
        end
        chk("stuck_hold", badcyc, 0);
`endif
        tx_stuck = 0;
        do_reset();
        // Held req after ack: repeat frame only when alone.
        req_data[7:0] = 8'h3C;
        req = 4'b0001;
        serve(0, 0, 0, lat);
        serve(1, 0, 0, lat);
        quiet("alone_quiet");
        req_data[23:16] = 8'h5A;
        req = 4'b0101;
        serve(0, 0, 0, lat);
        serve(1, 0, 4'b0100, lat);
        quiet("pending_quiet");
        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            if (req == '0) begin
                logic [N-1:0] m;
                m = N'($urandom_range(1, 15));
                for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
                req = m;
            end
            frame_len = $urandom_range(2, 30);
            serve(1, ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 15)) : '0, 0, lat);
        end
        for (int k = 0; k < 8 && req != '0; k++) serve(1, 0, 0, lat);
        chk("drained", req, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers (command responder, telemetry, debug).
- Accepts per-requester byte requests and latches the winner's byte.
- Issues a single-cycle trmt to the transmitter, waits for its sticky tx_done level, then returns a one-cycle ack to the winner.
- Sits between requesters and the UART transmitter; owns all transmitter sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 16384, cycles allowed in WAIT before abort (used only with the optional feature); must exceed one full frame of 10 bits x 868 cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester request level; held until ack.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]; stable while req[i] is high.
- ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte finished (or aborted).
- err  output  1  one-cycle pulse coincident with ack when the byte was aborted by timeout.
- busy  output  1  high in every state except IDLE.
- gnt_id  output  3  index of the current or last winner.
- trmt  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  registered byte presented to the transmitter.
- tx_done  input  1  transmitter done level: set at frame end, cleared by the transmitter on the edge that samples trmt.

Behaviour:
- Reset: clk and rst only; the block is one clock domain.
  - rst high at any time (including mid-frame) forces state=IDLE.
  - ack=0, err=0, busy=0, trmt=0, tx_data=8'h00, gnt_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first after reset.
  - A frame already in progress in the transmitter is not cancelled by this block. The system resets both blocks together.
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Latch gnt_id=winner and tx_data=req_data[winner], then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - trmt=1 for exactly this cycle, then go to WAIT.
  - tx_data is already stable in this cycle and holds until the next grant.
- WAIT:
  - trmt=0.
  - When tx_done=1, go to ACK.
  - tx_done is guaranteed low from the first WAIT cycle, because the transmitter clears it on the ISSUE edge. No edge detection is needed.
- ACK:
  - ack[gnt_id]=1 for one cycle, last=gnt_id, then go to IDLE.
- Handshake:
  - A requester drops req[i] on the edge at which it samples ack[i]=1.
  - If req[i] is still high in the following IDLE cycle, that is a new request, arbitrated normally.
- Latency: req rises in IDLE cycle 0 -> trmt high in cycle 1 -> ack one cycle after tx_done is first sampled high in WAIT.
- Fairness: continuously asserted requesters are served strictly in rotation. No requester waits more than NUM_REQ-1 frames.
- Simultaneous events:
  - req changes in ISSUE, WAIT or ACK do not affect the current transfer.
  - A new req[j] raised in the same cycle as ack[i] is seen in the next IDLE.
- Never more than one bit of ack set. trmt is never high outside ISSUE.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter (width clog2(TIMEOUT_CYC)+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with tx_done still low, go to ACK with err=1 alongside ack.
  - tx_done and timeout in the same cycle: tx_done wins, err=0.
- Not defined: no counter; WAIT waits for tx_done indefinitely; err is tied to 0.

Test Plan:
- Reset, then req=4'b0001 with byte 0xA5 -> trmt one cycle later with tx_data=0xA5; ack=4'b0001 one cycle after tx_done; busy low afterwards.
- req=4'b1111 held continuously with bytes 0x10,0x11,0x12,0x13 -> transmitter sees 0x10,0x11,0x12,0x13,0x10 in order; exactly one trmt per frame.
- After requester 2 is served, req=4'b0101 -> requester 0 wins (rotation from last=2); a new req[1] raised during WAIT is served next.
- Assert rst during WAIT (~4000 cycles into a frame) -> all outputs 0 next cycle; after release, req=4'b0010 is granted to index 1.
- With UART_TX_ARB_TIMEOUT_EN and tx_done stuck low -> ack and err pulse together after TIMEOUT_CYC WAIT cycles; without the macro, busy stays high and err stays 0.
- Requester holds req for one extra cycle after ack -> a second frame is sent only if no other requester is pending.
